delay_line_ctrl: RTL

- Flow controller for the 8-bit, N-stage shift-register delay line (stage 0 in, stage N-1 out, whole line shifts on one enable).
- Turns the raw line into a valid/ready FIFO-like pipe: a producer pushes bytes, and a consumer receives each byte exactly N accepted pushes later.
- A flush sequence injects zero bubbles to drain the remaining valid bytes.
- Sits between the streaming interfaces and the shift-register instance; it drives the line's shift enable and data input.

---
 rtl/delay_line_pkg.sv | 14 +
 rtl/delay_line_ctrl_if.sv | 38 +++
 rtl/delay_line_sr.sv | 22 ++
 rtl/delay_line_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/delay_line_pkg.sv
// Shared types and constants for the delay-line flow controller.
package delay_line_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StFull  = 2'd2,
    StFlush = 2'd3
  } state_e;

  localparam int unsigned DefaultDepth = 20000;
  localparam logic [7:0]  Bubble       = 8'h00;

endpackage

// File: rtl/delay_line_ctrl_if.sv
// Streaming, control and shift-register signals of the delay-line controller.
interface delay_line_ctrl_if
  import delay_line_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
);
  logic          hold;
  logic          clear;
  logic          flush_req;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          sr_shift_en;
  logic [7:0]    sr_data_in;
  logic [7:0]    sr_data_out;
  logic [CW-1:0] occupancy;
  state_e        state;
  logic          flush_done;

  modport master (
    output hold, clear, flush_req, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy, state, flush_done
  );

  modport slave (
    input  hold, clear, flush_req, in_valid, in_data, out_ready, sr_data_out,
    output in_ready, out_valid, out_data, occupancy, state, flush_done, sr_shift_en, sr_data_in
  );

  modport line (
    input  sr_shift_en, sr_data_in,
    output sr_data_out
  );
endinterface

// File: rtl/delay_line_sr.sv
// Plain 8-bit shift-register delay line; the whole line advances on one enable.
module delay_line_sr
  import delay_line_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth
) (
  input logic              clk,
  delay_line_ctrl_if.line  line
);
  logic [7:0] r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (line.sr_shift_en) begin
      r_stage[0] <= line.sr_data_in;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign line.sr_data_out = r_stage[DEPTH-1];
endmodule

// File: rtl/delay_line_ctrl.sv
// Valid/ready flow controller for a DEPTH-stage shift-register delay line,
// with a bubble-injecting flush that drains the remaining valid bytes.
module delay_line_ctrl
  import delay_line_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input logic              clk,
  input logic              rst,
  delay_line_ctrl_if.slave bus
);
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  state_e        r_state, w_state_d;
  logic [CW-1:0] r_occ, w_occ_d;
  logic [CW-1:0] r_lead, w_lead_d;
  logic          r_flush_done, w_flush_done_d;
  logic [CW:0]   w_top;
  logic          w_full, w_top_full;
  logic          w_in_ready, w_out_valid, w_shift, w_push;

  // Valid bytes occupy stages [lead, lead+occ-1]; top is one past the block.
  assign w_top      = {1'b0, r_lead} + {1'b0, r_occ};
  assign w_full     = (r_occ == DepthC);
  assign w_top_full = (w_top == {1'b0, DepthC});

  always_comb begin
    w_state_d      = r_state;
    w_occ_d        = r_occ;
    w_lead_d       = r_lead;
    w_flush_done_d = 1'b0;
    w_in_ready     = 1'b0;
    w_out_valid    = 1'b0;
    w_shift        = 1'b0;
    w_push         = 1'b0;

    if (bus.clear) begin
      w_state_d = StIdle;
      w_occ_d   = '0;
      w_lead_d  = '0;
    end else if (!bus.hold) begin
      if (r_state == StFlush) begin
        w_out_valid = w_top_full && (r_occ != '0);
        w_shift     = !w_top_full || bus.out_ready;
        if (w_shift) begin
          w_lead_d = r_lead + 1'b1;
        end
        if (w_top_full && bus.out_ready && (r_occ != '0)) begin
          w_occ_d = r_occ - 1'b1;
        end
        if (w_occ_d == '0) begin
          w_state_d      = StIdle;
          w_lead_d       = '0;
          w_flush_done_d = 1'b1;
        end
      end else begin
        // A pop only rides along with a push, so the block stays contiguous.
        w_in_ready  = !bus.flush_req && (!w_full || bus.out_ready);
        w_out_valid = w_full && bus.in_valid && !bus.flush_req;
        w_push      = bus.in_valid && w_in_ready;
        w_shift     = w_push;
        if (w_push && !w_full) begin
          w_occ_d = r_occ + 1'b1;
        end
        if (bus.flush_req) begin
          if (r_occ == '0) begin
            w_flush_done_d = 1'b1;
          end else begin
            w_state_d = StFlush;
          end
        end else if (w_occ_d == '0) begin
          w_state_d = StIdle;
        end else if (w_occ_d == DepthC) begin
          w_state_d = StFull;
        end else begin
          w_state_d = StFill;
        end
      end
    end

    if (rst) begin
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_shift     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_occ        <= '0;
      r_lead       <= '0;
      r_flush_done <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_occ        <= w_occ_d;
      r_lead       <= w_lead_d;
      r_flush_done <= w_flush_done_d;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_data    = bus.sr_data_out;
  assign bus.sr_shift_en = w_shift;
  assign bus.sr_data_in  = (r_state == StFlush) ? Bubble : bus.in_data;
  assign bus.occupancy   = r_occ;
  assign bus.state       = r_state;
  assign bus.flush_done  = r_flush_done;

  a_top_bound: assert property (@(posedge clk) disable iff (rst) w_top <= {1'b0, DepthC});
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    (r_state == StFlush) |-> (r_occ != '0));
endmodule
